// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Two-requester arbiter in front of a single-port RAM. A fetch (IF) and a
//   load/store (LS) requester compete for the RAM. The winner's command is
//   latched, the RAM is driven for WAIT_STATES+1 cycles, and then
//   memory-function-complete (mfc) is held until the requester drops its
//   request (four-phase handshake). Ties are broken round-robin.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   if_req/if_rw/if_addr/if_wdata     fetch requester (rw: 1=read, 0=write)
//   ls_req/ls_rw/ls_addr/ls_wdata     load/store requester
//   if_gnt, ls_gnt                    grant, one-hot or zero
//   if_mfc, ls_mfc                    completion to the granted requester
//   rdata                             registered read data
//   ram_en/ram_we/ram_addr/ram_wdata  RAM command port
//   ram_rdata                         RAM read data, valid by last ACCESS cycle
module mem_bus_arbiter #(
    parameter int AW          = 8,
    parameter int DW          = 16,
    parameter int WAIT_STATES = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic          if_rw,
    input  logic [AW-1:0] if_addr,
    input  logic [DW-1:0] if_wdata,
    input  logic          ls_req,
    input  logic          ls_rw,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          if_gnt,
    output logic          ls_gnt,
    output logic          if_mfc,
    output logic          ls_mfc,
    output logic [DW-1:0] rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          last_ls_q, last_ls_d;   // 1: most recent grant went to LS
    logic          if_gnt_q, if_gnt_d;
    logic          ls_gnt_q, ls_gnt_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;

    logic          pick_ls;
    logic          granted_req;
    logic          in_access;
    logic          is_write;

    // LS wins when it is the only requester, or on a tie when IF was served last.
    assign pick_ls     = ls_req && (!if_req || !last_ls_q);
    assign granted_req = (if_gnt_q && if_req) || (ls_gnt_q && ls_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_ls_q <= 1'b0;
            if_gnt_q  <= 1'b0;
            ls_gnt_q  <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_ls_q <= last_ls_d;
            if_gnt_q  <= if_gnt_d;
            ls_gnt_q  <= ls_gnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_ls_d = last_ls_q;
        if_gnt_d  = if_gnt_q;
        ls_gnt_d  = ls_gnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    last_ls_d = pick_ls;
                    if_gnt_d  = !pick_ls;
                    ls_gnt_d  = pick_ls;
                    rw_d      = pick_ls ? ls_rw    : if_rw;
                    addr_d    = pick_ls ? ls_addr  : if_addr;
                    wdata_d   = pick_ls ? ls_wdata : if_wdata;
                end
            end
            ACCESS: begin
                // The access always runs to completion, even if req drops.
                if (cnt_q == LAST_CNT) begin
                    state_d = RESP;
                    if (rw_q) begin
                        rdata_d = ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (!granted_req) begin
                    state_d  = IDLE;
                    if_gnt_d = 1'b0;
                    ls_gnt_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM outputs decode straight from state so an async reset drops them at once.
    assign in_access = (state_q == ACCESS);
    assign is_write  = in_access && !rw_q;

    assign ram_en    = in_access;
    assign ram_we    = is_write;
    assign ram_addr  = in_access ? addr_q : '0;
    assign ram_wdata = is_write ? wdata_q : '0;

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_mfc    = (state_q == RESP) && if_gnt_q;
    assign ls_mfc    = (state_q == RESP) && ls_gnt_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req, if_rw, ls_req, ls_rw;
    logic [7:0]  if_addr, ls_addr;
    logic [15:0] if_wdata, ls_wdata, ram_rdata;
    logic        if_gnt, ls_gnt, if_mfc, ls_mfc, ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_wdata, rdata;

    // Second instance with zero wait states.
    logic        z_if_req, z_if_rw, z_ls_req, z_ls_rw;
    logic [7:0]  z_if_addr, z_ls_addr;
    logic [15:0] z_if_wdata, z_ls_wdata, z_ram_rdata;
    logic        z_if_gnt, z_ls_gnt, z_if_mfc, z_ls_mfc, z_ram_en, z_ram_we;
    logic [7:0]  z_ram_addr;
    logic [15:0] z_ram_wdata, z_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_bus_arbiter #(.AW(8), .DW(16), .WAIT_STATES(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_rw(if_rw), .if_addr(if_addr), .if_wdata(if_wdata),
        .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .if_gnt(if_gnt), .ls_gnt(ls_gnt), .if_mfc(if_mfc), .ls_mfc(ls_mfc),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    mem_bus_arbiter #(.AW(8), .DW(16), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(z_if_req), .if_rw(z_if_rw), .if_addr(z_if_addr), .if_wdata(z_if_wdata),
        .ls_req(z_ls_req), .ls_rw(z_ls_rw), .ls_addr(z_ls_addr), .ls_wdata(z_ls_wdata),
        .if_gnt(z_if_gnt), .ls_gnt(z_ls_gnt), .if_mfc(z_if_mfc), .ls_mfc(z_ls_mfc),
        .rdata(z_rdata), .ram_en(z_ram_en), .ram_we(z_ram_we), .ram_addr(z_ram_addr),
        .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        if_req, if_rw;
        logic [7:0]  if_addr;
        logic [15:0] if_wdata;
        logic        ls_req, ls_rw;
        logic [7:0]  ls_addr;
        logic [15:0] ls_wdata;
        logic [15:0] ram_rdata;
    } in_t;

    typedef struct packed {
        logic        if_gnt, ls_gnt, if_mfc, ls_mfc, en, we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } out_t;

    in_t  ins[$];
    out_t exps[$];

    function automatic in_t mk_in(logic ir, logic irw, logic [7:0] ia, logic [15:0] iw,
                                  logic lr, logic lrw, logic [7:0] la, logic [15:0] lw,
                                  logic [15:0] rd);
        in_t r;
        r = '{ir, irw, ia, iw, lr, lrw, la, lw, rd};
        return r;
    endfunction

    function automatic out_t mk_out(logic gi, logic gl, logic mi, logic ml, logic en,
                                    logic we, logic [7:0] a, logic [15:0] wd,
                                    logic [15:0] rd);
        out_t r;
        r = '{gi, gl, mi, ml, en, we, a, wd, rd};
        return r;
    endfunction

    task automatic add(input in_t i, input out_t o, input int reps);
        for (int r = 0; r < reps; r++) begin
            ins.push_back(i);
            exps.push_back(o);
        end
    endtask

    task automatic drive(input in_t i);
        if_req = i.if_req;  if_rw = i.if_rw;  if_addr = i.if_addr;  if_wdata = i.if_wdata;
        ls_req = i.ls_req;  ls_rw = i.ls_rw;  ls_addr = i.ls_addr;  ls_wdata = i.ls_wdata;
        ram_rdata = i.ram_rdata;
    endtask

    function automatic out_t sample();
        out_t r;
        r = '{if_gnt, ls_gnt, if_mfc, ls_mfc, ram_en, ram_we, ram_addr, ram_wdata, rdata};
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    in_t  rd_ls, wr_a, wr_b, c_a, c_b, d_a, d_b, d_c;
    out_t act;
    int   n;
    logic seen;

    initial begin
        rst = 1'b1;
        drive('0);
        z_if_req = 0; z_if_rw = 0; z_if_addr = 0; z_if_wdata = 0;
        z_ls_req = 0; z_ls_rw = 0; z_ls_addr = 0; z_ls_wdata = 0; z_ram_rdata = 0;

        // LS read of 0x12 returning 0xBEEF.
        rd_ls = mk_in(0, 0, 8'h00, 16'h0, 1, 1, 8'h12, 16'h0, 16'hBEEF);
        add(rd_ls, mk_out(0, 1, 0, 0, 1, 0, 8'h12, 16'h0, 16'h0), 3);
        add(rd_ls, mk_out(0, 1, 0, 1, 0, 0, 8'h00, 16'h0, 16'hBEEF), 2);
        add(mk_in(0, 0, 8'h00, 16'h0, 0, 1, 8'h12, 16'h0, 16'hBEEF),
            mk_out(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'hBEEF), 1);
        // LS write 0x1234 to 0x05; inputs change after grant; rdata untouched.
        wr_a = mk_in(0, 0, 8'h00, 16'h0, 1, 0, 8'h05, 16'h1234, 16'hDEAD);
        wr_b = mk_in(0, 0, 8'h00, 16'h0, 1, 0, 8'h06, 16'hAAAA, 16'hDEAD);
        add(wr_a, mk_out(0, 1, 0, 0, 1, 1, 8'h05, 16'h1234, 16'hBEEF), 1);
        add(wr_b, mk_out(0, 1, 0, 0, 1, 1, 8'h05, 16'h1234, 16'hBEEF), 2);
        add(wr_b, mk_out(0, 1, 0, 1, 0, 0, 8'h00, 16'h0, 16'hBEEF), 3);
        add(mk_in(0, 0, 8'h00, 16'h0, 0, 0, 8'h06, 16'hAAAA, 16'hDEAD),
            mk_out(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'hBEEF), 1);
        // IF read of 0x20; address moves to 0x30 during ACCESS.
        c_a = mk_in(1, 1, 8'h20, 16'h0, 0, 0, 8'h00, 16'h0, 16'h5A5A);
        c_b = mk_in(1, 1, 8'h30, 16'hFFFF, 0, 0, 8'h00, 16'h0, 16'h5A5A);
        add(c_a, mk_out(1, 0, 0, 0, 1, 0, 8'h20, 16'h0, 16'hBEEF), 1);
        add(c_b, mk_out(1, 0, 0, 0, 1, 0, 8'h20, 16'h0, 16'hBEEF), 2);
        add(c_b, mk_out(1, 0, 1, 0, 0, 0, 8'h00, 16'h0, 16'h5A5A), 1);
        add(mk_in(0, 1, 8'h30, 16'h0, 0, 0, 8'h00, 16'h0, 16'h5A5A),
            mk_out(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h5A5A), 1);
        // IF drops req mid-ACCESS while LS waits; LS is served afterwards.
        d_a = mk_in(1, 1, 8'h40, 16'h0, 0, 0, 8'h00, 16'h0, 16'h1111);
        d_b = mk_in(0, 1, 8'h40, 16'h0, 1, 1, 8'h41, 16'h0, 16'h1111);
        d_c = mk_in(0, 1, 8'h40, 16'h0, 1, 1, 8'h41, 16'h0, 16'h2222);
        add(d_a, mk_out(1, 0, 0, 0, 1, 0, 8'h40, 16'h0, 16'h5A5A), 1);
        add(d_b, mk_out(1, 0, 0, 0, 1, 0, 8'h40, 16'h0, 16'h5A5A), 2);
        add(d_b, mk_out(1, 0, 1, 0, 0, 0, 8'h00, 16'h0, 16'h1111), 1);
        add(d_b, mk_out(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h1111), 1);
        add(d_c, mk_out(0, 1, 0, 0, 1, 0, 8'h41, 16'h0, 16'h1111), 3);
        add(d_c, mk_out(0, 1, 0, 1, 0, 0, 8'h00, 16'h0, 16'h2222), 1);
        add(mk_in(0, 1, 8'h40, 16'h0, 0, 1, 8'h41, 16'h0, 16'h2222),
            mk_out(0, 0, 0, 0, 0, 0, 8'h00, 16'h0, 16'h2222), 1);

        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", 64'(sample()), 64'(out_t'(0)));
        rst = 1'b0;

        for (int k = 0; k < ins.size(); k++) begin
            drive(ins[k]);
            cyc();
            act = sample();
            check($sformatf("vec%0d", k), 64'(act), 64'(exps[k]));
        end

        // Reset clears rdata; then a simultaneous request goes to LS first.
        rst = 1'b1;
        #3;
        check("reset_again", 64'(sample()), 64'(out_t'(0)));
        cyc();
        rst = 1'b0;
        drive(mk_in(1, 1, 8'h10, 16'h0, 1, 1, 8'h11, 16'h0, 16'h7777));
        cyc();
        check("tie1_gnt", {if_gnt, ls_gnt}, 2'b01);
        check("tie1_addr", 64'(ram_addr), 64'h11);
        n = 0;
        while (!ls_mfc && n < 20) begin cyc(); n++; end
        check("tie1_ls_mfc", {ls_mfc, if_mfc, if_gnt}, 3'b100);
        ls_req = 1'b0;
        cyc();
        check("tie1_idle", {if_gnt, ls_gnt, if_mfc, ls_mfc}, 4'b0000);
        cyc();
        check("if_after_ls", {if_gnt, ls_gnt, ram_en}, 3'b101);
        n = 0;
        while (!if_mfc && n < 20) begin cyc(); n++; end
        check("if_mfc", {if_mfc, rdata}, {1'b1, 16'h7777});
        if_req = 1'b0;
        cyc();
        check("if_idle", {if_gnt, ls_gnt}, 2'b00);
        if_req = 1'b1;
        ls_req = 1'b1;
        cyc();
        check("tie2_gnt", {if_gnt, ls_gnt}, 2'b01);
        if_req = 1'b0;
        ls_req = 1'b0;
        n = 0;
        while (ls_gnt && n < 20) begin cyc(); n++; end

        // Reset asserted during the second ACCESS cycle.
        drive(mk_in(1, 1, 8'h50, 16'h0, 0, 0, 8'h00, 16'h0, 16'h3333));
        cyc();
        check("rst_acc1", {if_gnt, ram_en, ram_addr}, {2'b11, 8'h50});
        cyc();
        #1;
        rst = 1'b1;
        if_req = 1'b0;
        #1;
        check("rst_mid_access", 64'(sample()), 64'(out_t'(0)));
        cyc();
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc();
            seen = seen | if_gnt | ls_gnt | if_mfc | ls_mfc | ram_en;
        end
        check("rst_no_mfc", 64'(seen), 64'h0);
        if_req = 1'b1;
        cyc();
        check("post_rst_gnt", {if_gnt, ls_gnt, ram_en}, 3'b101);
        if_req = 1'b0;

        // Zero wait states: one ACCESS cycle, mfc two edges after the request.
        z_if_req = 1'b1; z_if_rw = 1'b1; z_if_addr = 8'h33; z_ram_rdata = 16'h0F0F;
        cyc();
        check("ws0_access", {z_if_gnt, z_ram_en, z_if_mfc, z_ram_addr}, {3'b110, 8'h33});
        cyc();
        check("ws0_mfc", {z_if_gnt, z_ram_en, z_if_mfc, z_rdata}, {3'b101, 16'h0F0F});
        z_if_req = 1'b0;
        cyc();
        check("ws0_idle", {z_if_gnt, z_if_mfc, z_ram_en}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter AW, default 8, memory address width.
REQ-002 SHALL have parameter DW, default 16, data width.
REQ-003 SHALL have parameter WAIT_STATES, default 2, extra RAM access cycles (legal 0..15).
REQ-004 clk  in  1  clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset: asynchronous, active-high.
REQ-006 if_req, if_rw, if_addr, if_wdata  in  1,1,AW,DW  fetch requester: request level, 1=read/0=write, address, write data.
REQ-007 ls_req, ls_rw, ls_addr, ls_wdata  in  1,1,AW,DW  load/store requester: same meaning as the fetch requester.
REQ-008 if_gnt, ls_gnt  out  1 each  grant; one-hot or zero.
REQ-009 if_mfc, ls_mfc  out  1 each  memory-function-complete to the granted requester.
REQ-010 rdata  out  DW  registered read data.
REQ-011 ram_en, ram_we, ram_addr, ram_wdata  out  1,1,AW,DW  RAM port: enable, write enable, address, write data.
REQ-012 ram_rdata  in  DW  RAM read data; valid by the last ACCESS cycle.

Function
REQ-013 SHALL implement states IDLE, ACCESS, RESP.
REQ-014 IDLE: on any request, SHALL select a requester, latch its rw/addr/wdata into internal registers, set its gnt, and enter ACCESS on the next edge.
REQ-015 Arbitration: single request -> that requester; both requesting -> the one not granted last (round-robin); last_gnt resets to IF, so the first tie goes to LS.
REQ-016 ACCESS SHALL last exactly WAIT_STATES+1 cycles, timed by a 4-bit counter cleared on ACCESS entry.
REQ-017 In ACCESS: ram_en=1, ram_we=~latched_rw, ram_addr=latched addr, ram_wdata=latched wdata; ram_we=0 and ram_wdata=0 for reads.
REQ-018 On the last ACCESS cycle of a read, rdata SHALL capture ram_rdata; writes leave rdata unchanged.
REQ-019 RESP: ram_en=0; mfc of the granted requester =1; gnt held.
REQ-020 RESP SHALL persist while the granted req stays 1 (four-phase handshake); when req=0, return to IDLE next edge, clear gnt and mfc.
REQ-021 Latency: req rises in IDLE at edge N -> gnt and ACCESS from N+1 -> mfc from N+2+WAIT_STATES.
REQ-022 Granted req dropping mid-ACCESS SHALL NOT abort the access; RESP is entered, mfc is high for 1 cycle, then IDLE.
REQ-023 Non-granted requester's inputs SHALL be ignored until IDLE; its request stays pending, with no mfc.
REQ-024 Latched address/data SHALL NOT follow requester input changes after grant.
REQ-025 Never more than one of if_gnt/ls_gnt, or of if_mfc/ls_mfc, high; mfc only with its own gnt.
REQ-026 WAIT_STATES=0 SHALL give a 1-cycle ACCESS.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, last_gnt=IF, all gnt/mfc/ram_* outputs=0, rdata=0, latched registers=0.
REQ-028 Reset mid-ACCESS SHALL deassert ram_en asynchronously; no mfc is issued for the aborted access.

Verification
REQ-029 ls_req=1, ls_rw=1, ls_addr=0x12, ram_rdata=0xBEEF, WAIT_STATES=2 -> ls_gnt at N+1, ram_en high 3 cycles, ls_mfc at N+4, rdata=0xBEEF.
REQ-030 if_req and ls_req rise together after reset -> LS served first; IF granted on the cycle after LS reaches IDLE; next tie goes to LS again.
REQ-031 Write: ls_rw=0, addr=0x05, wdata=0x1234 -> ram_we=1, ram_wdata=0x1234 for 3 cycles, rdata unchanged, ls_mfc held until ls_req drops.
REQ-032 if_addr changed from 0x20 to 0x30 during ACCESS -> ram_addr stays 0x20 throughout.
REQ-033 rst pulse on the 2nd ACCESS cycle -> all outputs 0 that cycle; no mfc; arbiter idle after release.
REQ-034 WAIT_STATES=0, if_req read -> ram_en for 1 cycle, if_mfc at N+2.
